off_board_arbiter: RTL and testbench

Round-robin arbiter that shares the single 32-bit off-board link among NUM_REQ requester streams. It sits upstream of the off-board serializer, on the same valid/ready word stream that the off-board decode path consumes. Each grant is framed as one header word carrying the source ID, followed by a payload burst. A burst ends on the requester's last flag or after MAX_BURST words, so no source can monopolise the link.

---
 rtl/off_board_arbiter.sv | 171 +++++++++++++++++
 tb/tb_off_board_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/off_board_arbiter.sv
// ============================================================================
// off_board_arbiter : round-robin framing arbiter onto a 32-bit off-board link
// Revision 1.0
// ============================================================================
`default_nettype none

module off_board_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         MAX_BURST = 16,
  parameter logic [7:0] HDR_TAG   = 8'hB0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ*32-1:0] t_data,
  input  logic [NUM_REQ-1:0]   t_valid,
  input  logic [NUM_REQ-1:0]   t_last,
  output logic [NUM_REQ-1:0]   t_ready,
  output logic [31:0]          i0_data,
  output logic                 i0_valid,
  output logic                 i0_last,
  input  logic                 i0_ready,
  output logic [3:0]           grant_id,
  output logic                 busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    last_grant_q, last_grant_d;
  logic [3:0]    grant_q, grant_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0]   data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  logic          slot_free;
  logic          g_valid, g_last;
  logic [31:0]   g_data;
  logic          any_req;
  logic [3:0]    pick;
  logic          burst_end;

  assign slot_free = !valid_q || i0_ready;

  // Mux the granted requester's stream out of the packed input buses.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 4'(i)) begin
        g_valid = t_valid[i];
        g_last  = t_last[i];
        g_data  = t_data[i*32 +: 32];
      end
    end
  end

  // Round-robin pick: lowest valid index above last_grant, else lowest overall.
  always_comb begin
    logic       found_hi;
    logic       found_lo;
    logic [3:0] pick_hi;
    logic [3:0] pick_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (t_valid[i]) begin
        if (4'(i) > last_grant_q) begin
          found_hi = 1'b1;
          pick_hi  = 4'(i);
        end else begin
          found_lo = 1'b1;
          pick_lo  = 4'(i);
        end
      end
    end
    any_req = found_hi || found_lo;
    pick    = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    t_ready = '0;
    if (state_q == S_DATA) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q == 4'(i)) t_ready[i] = slot_free;
      end
    end
  end

  assign burst_end = g_last || (beat_q == BW'(MAX_BURST - 1));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    beat_d       = beat_q;
    data_d       = data_q;
    last_d       = last_q;
    // An accepted word leaves the slot unless something new is loaded below.
    valid_d      = slot_free ? 1'b0 : valid_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (slot_free) begin
          data_d  = {HDR_TAG, 4'h0, grant_q, 16'h0000};
          valid_d = 1'b1;
          last_d  = 1'b0;
          beat_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (slot_free && g_valid) begin
          data_d  = g_data;
          valid_d = 1'b1;
          last_d  = burst_end;
          beat_d  = beat_q + BW'(1);
          if (burst_end) begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 4'(NUM_REQ - 1);
      grant_q      <= '0;
      beat_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      beat_q       <= beat_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
    end
  end

  assign i0_data  = data_q;
  assign i0_valid = valid_q;
  assign i0_last  = last_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_off_board_arbiter.sv
// ============================================================================
// tb_off_board_arbiter : scoreboard bench for off_board_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_off_board_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 16;

  logic                    clk;
  logic                    reset_n;
  logic [NUM_REQ*32-1:0]   t_data;
  logic [NUM_REQ-1:0]      t_valid;
  logic [NUM_REQ-1:0]      t_last;
  logic [NUM_REQ-1:0]      t_ready;
  logic [31:0]             i0_data;
  logic                    i0_valid;
  logic                    i0_last;
  logic                    i0_ready;
  logic [3:0]              grant_id;
  logic                    busy;

  logic [31:0] drv_data  [NUM_REQ];
  logic        drv_valid [NUM_REQ];
  logic        drv_last  [NUM_REQ];

  int n_pass;
  int n_total;
  logic [32:0] exp_q[$];
  logic        sb_en;
  logic        prev_stall;
  logic [32:0] prev_word;
  logic        done5;

  off_board_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .HDR_TAG   (8'hB0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .t_data   (t_data),
    .t_valid  (t_valid),
    .t_last   (t_last),
    .t_ready  (t_ready),
    .i0_data  (i0_data),
    .i0_valid (i0_valid),
    .i0_last  (i0_last),
    .i0_ready (i0_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    t_valid = '0;
    t_last  = '0;
    t_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      t_valid[i]         = drv_valid[i];
      t_last[i]          = drv_last[i];
      t_data[i*32 +: 32] = drv_data[i];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] hdr(input int id);
    return {8'hB0, 4'h0, 4'(id), 16'h0000};
  endfunction

  task automatic push(input logic [31:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Drives one packet on requester k; data words are base+0 .. base+n-1.
  task automatic send_pkt(input int k, input int n, input logic [31:0] base);
    for (int j = 0; j < n; j++) begin
      int waitc;
      drv_data[k]  = base + 32'(j);
      drv_last[k]  = (j == n - 1);
      drv_valid[k] = 1'b1;
      waitc = 0;
      @(negedge clk);
      while (!t_ready[k] && waitc < 2000) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 2000) begin
        n_total++;
        $display("FAIL handshake_timeout req%0d: got no t_ready, expected t_ready", k);
      end
      @(posedge clk);
      #1;
    end
    drv_valid[k] = 1'b0;
    drv_last[k]  = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops expected words as the DUT hands them downstream.
  always @(negedge clk) begin
    if (!reset_n || !sb_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {31'd0, i0_valid, i0_last, i0_data}, {31'd0, 1'b1, prev_word});
      end
      check("t_ready_onehot", 64'(($countones(t_ready) <= 1)), 64'd1);
      if (i0_valid && i0_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got %h last %b, expected none", i0_data, i0_last);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("i0_word", {31'd0, i0_last, i0_data}, {31'd0, e});
        end
      end
      prev_stall = i0_valid && !i0_ready;
      prev_word  = {i0_last, i0_data};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass     = 0;
    n_total    = 0;
    sb_en      = 1'b1;
    prev_stall = 1'b0;
    prev_word  = '0;
    done5      = 1'b0;
    reset_n    = 1'b0;
    i0_ready   = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_data[i]  = '0;
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i0_valid", 64'(i0_valid), 64'd0);
    check("rst_i0_data",  64'(i0_data),  64'd0);
    check("rst_i0_last",  64'(i0_last),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_t_ready",  64'(t_ready),  64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single requester 1, 3 words, latency of the header
    push(hdr(1), 1'b0);
    push(32'h1100_0000, 1'b0);
    push(32'h1100_0001, 1'b0);
    push(32'h1100_0002, 1'b1);
    fork
      send_pkt(1, 3, 32'h1100_0000);
    join_none
    @(negedge clk);
    check("lat_n0_valid", 64'(i0_valid), 64'd0);
    @(negedge clk);
    check("lat_n1_valid", 64'(i0_valid), 64'd0);
    check("lat_n1_busy",  64'(busy),     64'd1);
    @(negedge clk);
    check("lat_n2_valid", 64'(i0_valid), 64'd1);
    check("lat_n2_hdr",   64'(i0_data),  64'(hdr(1)));
    wait fork;
    drain();

    // All requesters, 1-word packets, from reset: IDs 0,1,2,3,0
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    push(hdr(0), 1'b0); push(32'h3000_0000, 1'b1);
    push(hdr(1), 1'b0); push(32'h3100_0000, 1'b1);
    push(hdr(2), 1'b0); push(32'h3200_0000, 1'b1);
    push(hdr(3), 1'b0); push(32'h3300_0000, 1'b1);
    push(hdr(0), 1'b0); push(32'h3000_0100, 1'b1);
    fork
      begin
        send_pkt(0, 1, 32'h3000_0000);
        send_pkt(0, 1, 32'h3000_0100);
      end
      send_pkt(1, 1, 32'h3100_0000);
      send_pkt(2, 1, 32'h3200_0000);
      send_pkt(3, 1, 32'h3300_0000);
    join
    drain();

    // Requester 2 sends 40 words: bursts of 16/16/8, requester 0 served between
    for (int j = 0; j < 40; j++) begin
      if (j == 0 || j == 16 || j == 32) push(hdr(2), 1'b0);
      push(32'h2000_0000 + 32'(j), (j == 15 || j == 31 || j == 39));
      if (j == 15) begin push(hdr(0), 1'b0); push(32'h0A00_0000, 1'b1); end
      if (j == 31) begin push(hdr(0), 1'b0); push(32'h0A00_0001, 1'b1); end
    end
    fork
      send_pkt(2, 40, 32'h2000_0000);
      begin
        repeat (5) @(posedge clk);
        #1;
        send_pkt(0, 1, 32'h0A00_0000);
        send_pkt(0, 1, 32'h0A00_0001);
      end
    join
    drain();

    // Random downstream backpressure, requesters 3 and 1 concurrently
    push(hdr(3), 1'b0);
    for (int j = 0; j < 5; j++) push(32'h5300_0000 + 32'(j), (j == 4));
    push(hdr(1), 1'b0);
    for (int j = 0; j < 10; j++) push(32'h5100_0000 + 32'(j), (j == 9));
    done5 = 1'b0;
    fork
      begin
        fork
          send_pkt(3, 5, 32'h5300_0000);
          send_pkt(1, 10, 32'h5100_0000);
        join
        done5 = 1'b1;
      end
      begin
        while (!done5) begin
          @(posedge clk);
          #1;
          i0_ready = 1'($urandom_range(0, 1));
        end
        i0_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-burst of requester 3
    sb_en        = 1'b0;
    drv_data[3]  = 32'h6300_0000;
    drv_last[3]  = 1'b0;
    drv_valid[3] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_busy",     64'(busy),     64'd1);
    check("mid_i0_valid", 64'(i0_valid), 64'd1);
    check("mid_grant",    64'(grant_id), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_i0_valid", 64'(i0_valid), 64'd0);
    check("arst_t_ready",  64'(t_ready),  64'd0);
    check("arst_busy",     64'(busy),     64'd0);
    drv_valid[3] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb_en   = 1'b1;
    push(hdr(0), 1'b0); push(32'h7000_0000, 1'b1);
    push(hdr(3), 1'b0); push(32'h7300_0000, 1'b1);
    fork
      send_pkt(0, 1, 32'h7000_0000);
      send_pkt(3, 1, 32'h7300_0000);
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
